// File: rtl/receiver_rr.sv
// Router input receiver: round-robin arbiter of PORTS_NUM+1 flit sources onto one FIFO write port,
// with optional wormhole lock and a stall timeout that aborts dead packets.
module receiver_rr #(
    parameter  int DATA_SIZE = 4,
    parameter  int ADDR_SIZE = 1,
    parameter  int PORTS_NUM = 4,
    parameter  int PKT_LOCK  = 1,
    parameter  int TIMEOUT   = 8,
    localparam int FLIT      = DATA_SIZE + ADDR_SIZE + 1,
    localparam int NP        = PORTS_NUM + 1,
    localparam int PW        = $clog2(NP)
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic               is_full,
    input  logic [NP-1:0]      wr_ready_in,
    input  logic [FLIT*NP-1:0] data_i,
    output logic               wr_req,
    output logic [NP-1:0]      r_ready_out,
    output logic [FLIT-1:0]    data_o,
    output logic [PW-1:0]      cur_port,
    output logic               pkt_abort
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   stall_cnt;
    logic [FLIT-1:0] flit_sel;
    logic [PW-1:0]   pick;
    logic            any_req;
    logic            xfer;

    assign flit_sel = data_i[int'(cur_port)*FLIT +: FLIT];
    assign xfer     = (state == XFER) && !is_full && wr_ready_in[cur_port];

    always_comb begin
        r_ready_out = '0;
        if (state == XFER && !is_full)
            r_ready_out[cur_port] = 1'b1;
    end

    // Scan farthest-first so the nearest requester after ptr overwrites the pick last.
    always_comb begin
        pick    = ptr;
        any_req = 1'b0;
        for (int k = NP; k >= 1; k--) begin
            if (wr_ready_in[(int'(ptr) + k) % NP]) begin
                pick    = PW'((int'(ptr) + k) % NP);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_rst) begin
            state     <= IDLE;
            ptr       <= PW'(PORTS_NUM);
            wr_req    <= 1'b0;
            data_o    <= '0;
            cur_port  <= '0;
            pkt_abort <= 1'b0;
            stall_cnt <= '0;
        end else begin
            wr_req    <= xfer;
            pkt_abort <= 1'b0;
            if (xfer)
                data_o <= flit_sel;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_port <= pick;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (PKT_LOCK == 0 || flit_sel[FLIT-1]) begin
                            ptr   <= cur_port;
                            state <= IDLE;
                        end
                    end else if (!is_full) begin
                        // Only a silent source counts toward the timeout; FIFO backpressure never does.
                        if (TIMEOUT != 0 && stall_cnt == CW'(TIMEOUT - 1)) begin
                            pkt_abort <= 1'b1;
                            ptr       <= cur_port;
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end else if (stall_cnt != '1) begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
